// File: rtl/blu_pkg.sv
// Shared definitions for the sequential bitwise logic unit: opcode values,
// FSM state encoding and the slice-counter width helper.
package blu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_INV  = 3'b110;
  localparam logic [2:0] OP_BUF  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Counter width for NSLICE slices; never below one bit so NSLICE==1 still has a counter.
  function automatic int cnt_w(input int nslice);
    if (nslice <= 2) return 1;
    return $clog2(nslice);
  endfunction

endpackage

// File: rtl/blu_slice.sv
// Combinational SLICE-bit evaluator for one opcode of the bitwise logic unit.
module blu_slice
  import blu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [2:0]       i_op,
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic [SLICE-1:0] o_y
);

  // Opcode decode; b is ignored by INV and BUF.
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_XNOR: o_y = ~(i_a ^ i_b);
      OP_NAND: o_y = ~(i_a & i_b);
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_INV:  o_y = ~i_a;
      default: o_y = i_a;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit_seq.sv
// Multi-cycle bitwise logic unit: captures a, b and op, then evaluates SLICE
// bits per cycle (LSB slice first) with valid/ready handshakes on both sides.
// Optional build macro BLU_FLAGS_EN adds registered zero/parity outputs,
// accumulated slice by slice while the operation runs.
module bitwise_logic_unit_seq
  import blu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
`ifdef BLU_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_w(NSLICE);
  localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_y_sl;
  logic             w_accept;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_a_sl   = r_a[r_cnt*SLICE +: SLICE];
  assign w_b_sl   = r_b[r_cnt*SLICE +: SLICE];

  blu_slice #(.SLICE(SLICE)) u_slice (
    .i_op (r_op),
    .i_a  (w_a_sl),
    .i_b  (w_b_sl),
    .o_y  (w_y_sl)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; any unknown encoding falls back to IDLE.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = in_valid ? S_BUSY : S_IDLE;
      S_BUSY:  w_next = (r_cnt == CNT_LAST) ? S_DONE : S_BUSY;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, slice counter and per-slice result write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_y   <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
      r_y   <= '0;
    end else if (r_state == S_BUSY) begin
      r_y[r_cnt*SLICE +: SLICE] <= w_y_sl;
      r_cnt <= r_cnt + CW'(1);
    end
  end

`ifdef BLU_FLAGS_EN
  logic r_zero;
  logic r_parity;

  // Flags start neutral at accept and fold in each slice as it is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_zero   <= r_zero & (w_y_sl == '0);
      r_parity <= r_parity ^ (^w_y_sl);
    end
  end

  assign zero   = r_zero;
  assign parity = r_parity;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_BUSY);
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;

endmodule

// File: tb/tb_bitwise_logic_unit_seq.sv
// Self-checking bench for bitwise_logic_unit_seq (WIDTH=32, SLICE=4).
// Flag checks are compiled in when BLU_FLAGS_EN is defined.
module tb_bitwise_logic_unit_seq;

  localparam int WIDTH  = 32;
  localparam int NSLICE = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] y;
  logic             busy;
`ifdef BLU_FLAGS_EN
  logic             zero;
  logic             parity;
`endif

  int errors = 0;
  int checks = 0;

  bitwise_logic_unit_seq #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
`ifdef BLU_FLAGS_EN
    .zero      (zero),
    .parity    (parity),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: whole-vector bitwise result from the opcode table.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x ^ z);
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Present one operation while idle, scramble inputs after accept, and
  // wait (bounded) for out_valid; lat counts edges from accept to out_valid.
  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] z,
                       output logic [WIDTH-1:0] yv, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = z;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat <= 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    yv = y;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      op = 3'($urandom); a = $urandom; b = $urandom;
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
`ifdef BLU_FLAGS_EN
    checks++; if ({zero, parity} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {zero, parity}); end
`endif
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_xor();
    logic [WIDTH-1:0] yv;
    int lat;
    do_op(3'd2, 32'hFFFF0000, 32'h0F0F0F0F, yv, lat);
    checks++; if (lat !== NSLICE) begin errors++; $display("FAIL xor_latency got %0d want %0d", lat, NSLICE); end
    checks++; if (yv !== 32'hF0F00F0F) begin errors++; $display("FAIL xor_y got %h want f0f00f0f", yv); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL xor_done_flags got in_ready=%b busy=%b want 0 0", in_ready, busy); end
    handoff();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL xor_handoff got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    checks++; if (y !== 32'hF0F00F0F) begin errors++; $display("FAIL xor_y_kept got %h want f0f00f0f", y); end
  endtask

  task automatic test_all_ops();
    logic [WIDTH-1:0] yv;
    int lat;
    for (int o = 0; o < 8; o++) begin
      do_op(3'(o), 32'h12345678, 32'hFFFF0000, yv, lat);
      checks++; if (yv !== ref_op(3'(o), 32'h12345678, 32'hFFFF0000)) begin errors++; $display("FAIL op%0d_y got %h want %h", o, yv, ref_op(3'(o), 32'h12345678, 32'hFFFF0000)); end
      if (o == 6) begin
        checks++; if (yv !== 32'hEDCBA987) begin errors++; $display("FAIL inv_y got %h want edcba987", yv); end
      end
      if (o == 7) begin
        checks++; if (yv !== 32'h12345678) begin errors++; $display("FAIL buf_y got %h want 12345678", yv); end
      end
      handoff();
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] yv, x, z;
    int lat;
    x = $urandom; z = $urandom;
    do_op(3'd0, x, z, yv, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== (x & z)) begin errors++; $display("FAIL bp_hold%0d got ov=%b ir=%b y=%h want 1 0 %h", i, out_valid, in_ready, y, x & z); end
    end
    in_valid = 1'b0;
    handoff();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b ov=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] yv;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = 3'd7; a = 32'hFFFFFFFF; b = $urandom;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || y !== '0) begin errors++; $display("FAIL midreset got ir=%b ov=%b busy=%b y=%h want 1 0 0 0", in_ready, out_valid, busy, y); end
    @(negedge clk);
    reset_n = 1'b1;
    do_op(3'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, yv, lat);
    checks++; if (yv !== 32'hA5A5A5A5 || lat !== NSLICE) begin errors++; $display("FAIL after_reset_and got y=%h lat=%0d want a5a5a5a5 %0d", yv, lat, NSLICE); end
    handoff();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] yv, x, z;
    logic [2:0] o;
    int lat;
    for (int i = 0; i < 20; i++) begin
      o = 3'($urandom); x = $urandom; z = $urandom;
      do_op(o, x, z, yv, lat);
      checks++; if (yv !== ref_op(o, x, z) || lat !== NSLICE) begin errors++; $display("FAIL rand%0d got y=%h lat=%0d want %h %0d", i, yv, lat, ref_op(o, x, z), NSLICE); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      handoff();
    end
  endtask

`ifdef BLU_FLAGS_EN
  task automatic test_flags();
    logic [WIDTH-1:0] yv;
    int lat;
    do_op(3'd2, 32'h1, 32'h1, yv, lat);
    checks++; if (yv !== '0 || zero !== 1'b1 || parity !== 1'b0) begin errors++; $display("FAIL flags_xor got y=%h z=%b p=%b want 0 1 0", yv, zero, parity); end
    handoff();
    do_op(3'd1, 32'h7, 32'h0, yv, lat);
    checks++; if (yv !== 32'h7 || zero !== 1'b0 || parity !== 1'b1) begin errors++; $display("FAIL flags_or got y=%h z=%b p=%b want 7 0 1", yv, zero, parity); end
    handoff();
  endtask
`endif

  initial begin
    test_reset();
    test_xor();
    test_all_ops();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef BLU_FLAGS_EN
    test_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
